centroid_tracker: RTL and testbench
===================================

CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 Parameter IMG_W, default 1280, meaning active pixels per line SHALL be fixed at elaboration.
REQ-002 Parameter IMG_H, default 720, meaning active lines per frame SHALL be fixed at elaboration.
REQ-003 clk  input  1  sole clock SHALL be the only clock; all logic is rising-edge.
REQ-004 rst  input  1  reset SHALL be synchronous and active-high.
REQ-005 de_in, hsync_in, vsync_in  input  1 each  video timing from the binarisation stage SHALL be accepted.
REQ-006 pixel_in  input  24  mask pixel SHALL be accepted, {R,G,B}, with white meaning pixel_in[23:16] != 0.
REQ-007 de_out, hsync_out, vsync_out  output  1 each  timing delayed by exactly 1 cycle SHALL be driven.
REQ-008 pixel_out  output  24  delayed pixel, optionally with a marker overlay, SHALL be driven.
REQ-009 centroid_x  output  11  and centroid_y  output  10  last valid centroid SHALL be driven.
REQ-010 centroid_valid  output  1  one-cycle pulse on centroid update SHALL be driven.

Function
REQ-011 x counter SHALL increment each de_in=1 cycle and SHALL clear to 0 on the cycle after de_in falls.
REQ-012 y counter SHALL increment on each de_in falling edge and SHALL clear to 0 on vsync_in rising edge.
REQ-013 On each white pixel with de_in=1: sum_x += x, sum_y += y, count += 1; widths 31/30/20 bits, no overflow at IMG_W x IMG_H.
REQ-014 FSM states: ACCUM, DIVIDE, UPDATE. In ACCUM, a vsync_in rising edge latches sums and count, clears accumulators and moves to DIVIDE if count != 0, else stays in ACCUM.
REQ-015 DIVIDE SHALL start two divider_seq instances (sum_x/count, sum_y/count) together and wait until both assert done; the quotient is floor division.
REQ-016 UPDATE SHALL load centroid_x/centroid_y from the quotients, pulse centroid_valid for 1 cycle, set marker_ok=1 and return to ACCUM.
REQ-017 Frame-end to centroid_valid SHALL take at most 35 cycles.
REQ-018 A vsync_in rising edge during DIVIDE/UPDATE SHALL still clear the accumulators, but its latched result SHALL be dropped.
REQ-019 Accumulation SHALL continue during DIVIDE/UPDATE, because the latched copies decouple it.
REQ-020 A zero-count frame SHALL leave the centroid outputs unchanged and SHALL produce no centroid_valid.
REQ-021 pixel_out SHALL equal pixel_in delayed 1 cycle, except when the overlay of REQ-026 applies.

Reset
REQ-022 While rst=1, all outputs SHALL be 0 on the next edge.
REQ-023 While rst=1, counters, accumulators, latched values and marker_ok SHALL clear, and the FSM SHALL enter ACCUM.
REQ-024 rst during DIVIDE SHALL abort both dividers, and no centroid_valid SHALL follow.
REQ-025 After reset, the first frame SHALL be accumulated from its first vsync_in rising edge onward; the partial frame before it SHALL be discarded.

Configuration
REQ-026 With CENTROID_MARKER_EN defined: when marker_ok=1 and the delayed de=1 and (delayed x == centroid_x or delayed y == centroid_y), pixel_out SHALL be MARKER_COLOR (24'hFF0000).
REQ-027 Without CENTROID_MARKER_EN: pixel_out SHALL always equal the delayed pixel_in, while the centroid outputs still operate.

Structure
REQ-028 Package vision_pkg SHALL hold IMG_W, IMG_H, X_W=11, Y_W=10, the accumulator widths, MARKER_COLOR, and the FSM state enum.
REQ-029 Sub-module divider_seq SHALL be a restoring divider (32-bit dividend, 20-bit divisor, start/done, 32 cycles), instantiated twice.
REQ-030 The implementation SHALL be 120-400 lines of RTL in total, including divider_seq.

Verification
REQ-031 Single white pixel at (10,5) in one frame, then vsync rise -> centroid_valid pulse within 35 cycles, centroid_x=10, centroid_y=5.
REQ-032 2x2 white block at x=20..21, y=30..31 -> centroid_x=20, centroid_y=30 (floor of 20.5 / 30.5).
REQ-033 All-black frame after the REQ-031 frame -> no centroid_valid, and the outputs stay 10/5.
REQ-034 CENTROID_MARKER_EN defined, centroid (10,5), black input frame -> pixel_out=FF0000 at x=10 or y=5 while de_out=1, 000000 elsewhere; timing outputs equal the inputs delayed 1 cycle.
REQ-035 rst pulsed 10 cycles after a vsync rise (during DIVIDE) -> all outputs 0, no centroid_valid, and the next full frame with a pixel at (3,4) yields 3/4.
REQ-036 Macro undefined, random pixel_in stream -> pixel_out equals pixel_in delayed 1 cycle, bit-exact, for a full frame.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared image geometry, datapath widths, overlay colour and FSM state type for the
// centroid tracker.
package vision_pkg;

  localparam int unsigned IMG_W  = 1280;
  localparam int unsigned IMG_H  = 720;
  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned SUMX_W = 31;
  localparam int unsigned SUMY_W = 30;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned DIV_W  = 32;

  localparam logic [23:0] MARKER_COLOR = 24'hFF0000;

  typedef enum logic [1:0] {
    StAccum,
    StDivide,
    StUpdate
  } state_e;

endpackage

// File: rtl/divider_seq.sv
// Sequential restoring divider: 32-bit dividend, 20-bit divisor, one quotient bit per cycle.
// done_o stays high from completion until the next start_i.
module divider_seq #(
  parameter int unsigned QW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [31:0]   dividend_i,
  input  logic [19:0]   divisor_i,
  output logic [QW-1:0] quotient_o,
  output logic          done_o
);

  logic [19:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [19:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [20:0] rem_sh;
  logic [19:0] diff;
  logic        ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    ge     = rem_sh >= {1'b0, div_q};
    // Only meaningful when ge; the result then always fits in 20 bits.
    diff   = rem_sh[19:0] - div_q;

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;

    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      div_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      rem_d = ge ? diff : rem_sh[19:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = quo_q[QW-1:0];
  assign done_o     = done_q;

endmodule

// File: rtl/centroid_tracker.sv
// Tracks the centroid of white mask pixels per frame and passes video through with 1-cycle delay.
// Define CENTROID_MARKER_EN to overlay a cross-hair at the last centroid on pixel_out.
module centroid_tracker #(
  parameter int unsigned IMG_W = vision_pkg::IMG_W,
  parameter int unsigned IMG_H = vision_pkg::IMG_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      de_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [23:0]               pixel_in,
  output logic                      de_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [23:0]               pixel_out,
  output logic [vision_pkg::X_W-1:0] centroid_x,
  output logic [vision_pkg::Y_W-1:0] centroid_y,
  output logic                      centroid_valid
);

  import vision_pkg::*;

  logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [23:0]       pix_q, pix_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              armed_q, armed_d;
  logic [SUMX_W-1:0] sum_x_q, sum_x_d;
  logic [SUMY_W-1:0] sum_y_q, sum_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic [X_W-1:0]    cx_q, cx_d;
  logic [Y_W-1:0]    cy_q, cy_d;
  logic              valid_q, valid_d;
`ifdef CENTROID_MARKER_EN
  logic              marker_ok_q, marker_ok_d;
`endif

  logic           vsync_rise, de_fall, white, in_frame, div_start;
  logic           done_x, done_y;
  logic [X_W-1:0] quo_x;
  logic [Y_W-1:0] quo_y;

  assign vsync_rise = vsync_in & ~vs_q;
  assign de_fall    = de_q & ~de_in;
  assign white      = pixel_in[23:16] != 8'd0;
  assign in_frame   = (32'(x_q) < IMG_W) && (32'(y_q) < IMG_H);

  // Counters, accumulators and pixel path.
  always_comb begin
    de_d = de_in;
    hs_d = hsync_in;
    vs_d = vsync_in;

    x_d = de_in ? x_q + 1'b1 : '0;

    y_d = y_q;
    if (vsync_rise) begin
      y_d = '0;
    end else if (de_fall) begin
      y_d = y_q + 1'b1;
    end

    // Nothing is accumulated until the first frame start seen after reset.
    armed_d = armed_q | vsync_rise;

    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (vsync_rise) begin
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (armed_q && de_in && white && in_frame) begin
      sum_x_d = sum_x_q + SUMX_W'(x_q);
      sum_y_d = sum_y_q + SUMY_W'(y_q);
      cnt_d   = cnt_q + 1'b1;
    end

`ifdef CENTROID_MARKER_EN
    pix_d = (marker_ok_q && de_in && ((x_q == cx_q) || (y_q == cy_q))) ? MARKER_COLOR : pixel_in;
`else
    pix_d = pixel_in;
`endif
  end

  // Frame-end FSM; the dividers hold their own copies of the operands.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    cx_d      = cx_q;
    cy_d      = cy_q;
    valid_d   = 1'b0;
`ifdef CENTROID_MARKER_EN
    marker_ok_d = marker_ok_q;
`endif

    unique case (state_q)
      StAccum: begin
        if (vsync_rise && (cnt_q != '0)) begin
          div_start = 1'b1;
          state_d   = StDivide;
        end
      end
      StDivide: begin
        if (done_x && done_y) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        cx_d    = quo_x;
        cy_d    = quo_y;
        valid_d = 1'b1;
`ifdef CENTROID_MARKER_EN
        marker_ok_d = 1'b1;
`endif
        state_d = StAccum;
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      armed_q <= 1'b0;
      sum_x_q <= '0;
      sum_y_q <= '0;
      cnt_q   <= '0;
      state_q <= StAccum;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
`ifdef CENTROID_MARKER_EN
      marker_ok_q <= 1'b0;
`endif
    end else begin
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      y_q     <= y_d;
      armed_q <= armed_d;
      sum_x_q <= sum_x_d;
      sum_y_q <= sum_y_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
`ifdef CENTROID_MARKER_EN
      marker_ok_q <= marker_ok_d;
`endif
    end
  end

  divider_seq #(
    .QW(X_W)
  ) u_div_x (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (DIV_W'(sum_x_q)),
    .divisor_i  (cnt_q),
    .quotient_o (quo_x),
    .done_o     (done_x)
  );

  divider_seq #(
    .QW(Y_W)
  ) u_div_y (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .dividend_i (DIV_W'(sum_y_q)),
    .divisor_i  (cnt_q),
    .quotient_o (quo_y),
    .done_o     (done_y)
  );

  assign de_out         = de_q;
  assign hsync_out      = hs_q;
  assign vsync_out      = vs_q;
  assign pixel_out      = pix_q;
  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign centroid_valid = valid_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Self-checking bench for centroid_tracker: directed frames plus random frames checked against
// a frame-buffer model; honours CENTROID_MARKER_EN for the expected pixel stream.
module tb_centroid_tracker;

  localparam int W = 48;
  localparam int H = 36;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [23:0] pixel_in = '0;
  logic        de_out, hsync_out, vsync_out, centroid_valid;
  logic [23:0] pixel_out;
  logic [10:0] centroid_x;
  logic [9:0]  centroid_y;

  always #5 clk = ~clk;

  centroid_tracker #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .de_in          (de_in),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
    .pixel_in       (pixel_in),
    .de_out         (de_out),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .pixel_out      (pixel_out),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .centroid_valid (centroid_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every centroid_valid pulse.
  int          v_count = 0;
  int          v_cyc   = 0;
  logic [10:0] v_x     = '0;
  logic [9:0]  v_y     = '0;
  always @(negedge clk) begin
    if (centroid_valid === 1'b1) begin
      v_count = v_count + 1;
      v_cyc   = cyc;
      v_x     = centroid_x;
      v_y     = centroid_y;
    end
  end

  // Model state.
  logic [23:0] fb [H][W];
  int  m_cx = 0, m_cy = 0;
  bit  m_mok = 0;
  bit  pend_valid = 0;
  int  pend_x = 0, pend_y = 0;
  int  vc0 = 0, rise_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, then check the delayed outputs just after the edge.
  task automatic tick(input logic de, input logic hs, input logic vs, input logic [23:0] px,
                      input int x, input int y);
    logic [23:0] exp_px;
    de_in = de; hsync_in = hs; vsync_in = vs; pixel_in = px;
    @(posedge clk);
    #1;
    exp_px = px;
`ifdef CENTROID_MARKER_EN
    if (m_mok && de && (x == m_cx || y == m_cy)) exp_px = 24'hFF0000;
`endif
    if (rst) begin
      chk("rst_de_out", de_out, 0);
      chk("rst_pixel_out", pixel_out, 0);
      chk("rst_cx", centroid_x, 0);
      chk("rst_cy", centroid_y, 0);
      chk("rst_valid", centroid_valid, 0);
    end else begin
      chk("de_out", de_out, de);
      chk("hsync_out", hsync_out, hs);
      chk("vsync_out", vsync_out, vs);
      chk("pixel_out", pixel_out, exp_px);
    end
  endtask

  task automatic blank();
    tick(1'b0, 1'b0, 1'b0, 24'h0, -1, -1);
  endtask

  // Frame start; dbl inserts a short white line and a second vsync rise while dividing.
  task automatic vblank(input bit dbl);
    tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    rise_cyc = cyc;
    repeat (2) tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    if (dbl) begin
      repeat (3) blank();
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 24'h801234, i, 0);
      blank();
      repeat (3) tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    end
    repeat (40) blank();
  endtask

  task automatic lines();
    for (int y = 0; y < H; y++) begin
      blank();
      repeat (2) tick(1'b0, 1'b1, 1'b0, 24'h0, -1, -1);
      blank();
      for (int x = 0; x < W; x++) tick(1'b1, 1'b0, 1'b0, fb[y][x], x, y);
    end
    repeat (4) blank();
  endtask

  task automatic model_frame();
    int sx, sy, n;
    sx = 0; sy = 0; n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (fb[y][x][23:16] != 8'd0) begin
          sx += x; sy += y; n++;
        end
    pend_valid = (n != 0);
    if (n != 0) begin
      pend_x = sx / n;
      pend_y = sy / n;
    end
  endtask

  task automatic check_result(input string tag);
    if (pend_valid) begin
      chk({tag, "_vcount"}, v_count, vc0 + 1);
      chk({tag, "_latency_le35"}, ((v_cyc - rise_cyc) <= 35) ? 1 : 0, 1);
      chk({tag, "_vx"}, v_x, pend_x);
      chk({tag, "_vy"}, v_y, pend_y);
      m_cx = pend_x; m_cy = pend_y; m_mok = 1;
    end else begin
      chk({tag, "_novalid"}, v_count, vc0);
    end
    chk({tag, "_cx"}, centroid_x, m_cx);
    chk({tag, "_cy"}, centroid_y, m_cy);
  endtask

  task automatic frame(input string prev_tag, input bit dbl);
    vc0 = v_count;
    vblank(dbl);
    check_result(prev_tag);
    lines();
    model_frame();
  endtask

  task automatic fb_clear();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fb[y][x] = 24'h0;
  endtask

  task automatic fb_noise(input int white_pct, input bit full_random);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (full_random) fb[y][x] = 24'($urandom);
        else if ($urandom_range(99) < white_pct)
          fb[y][x] = {8'($urandom_range(255, 1)), 16'($urandom)};
        else fb[y][x] = {8'h00, 16'($urandom)};
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 1'b1, 24'hABCDEF, -1, -1);
    rst = 1'b0;
    blank();

    // Partial frame before any vsync must be discarded.
    fb_noise(50, 1'b0);
    lines();
    pend_valid = 0;

    fb_clear(); fb[5][10] = 24'hFF_FFFF;
    frame("partial_discard", 1'b0);
    fb_clear();
    frame("single_10_5", 1'b0);
    fb_clear();
    fb[30][20] = 24'h010000; fb[30][21] = 24'h800000;
    fb[31][20] = 24'hFFFFFF; fb[31][21] = 24'h0100FF;
    frame("black_keeps_10_5", 1'b0);
    fb_noise(10, 1'b0);
    frame("block_20_30", 1'b0);
    fb_noise(0, 1'b1);
    frame("sparse_random", 1'b1);
    fb_noise(30, 1'b0);
    frame("full_random_dbl_vsync", 1'b0);

    // Reset 10 cycles after the frame-end vsync rise, while dividing.
    vc0 = v_count;
    repeat (3) tick(1'b0, 1'b0, 1'b1, 24'h0, -1, -1);
    repeat (7) blank();
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0, 24'h123456, -1, -1);
    rst = 1'b0;
    m_mok = 0; m_cx = 0; m_cy = 0; pend_valid = 0;
    repeat (40) blank();
    chk("rst_div_novalid", v_count, vc0);
    chk("rst_div_cx", centroid_x, 0);
    chk("rst_div_cy", centroid_y, 0);

    fb_noise(50, 1'b0);
    lines();
    pend_valid = 0;
    fb_clear(); fb[4][3] = 24'h400000;
    frame("post_rst_partial", 1'b0);
    fb_clear();
    frame("post_rst_3_4", 1'b0);
    vc0 = v_count;
    vblank(1'b0);
    check_result("final_black");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
